// File: rtl/rx_packet_sequencer.sv
// Framed RX byte sequencer: hunts 0xA5 sync, takes LEN, forwards LEN payload bytes,
// then checks an XOR checksum. Pulls bytes from a registered-output FIFO, one read in flight.
module rx_packet_sequencer #(
    parameter int MAX_LEN      = 64,
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_fifo_output_byte,
    input  logic        i_fifo_is_empty_sig,
    output logic        o_read_next_byte_cmd,
    input  logic        i_sink_ready,
    output logic [7:0]  o_payload_byte,
    output logic        o_payload_valid,
    output logic        o_packet_start,
    output logic        o_packet_done,
    output logic        o_packet_ok,
    output logic [7:0]  o_length,
    output logic [7:0]  o_error_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    localparam int              TW        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      SYNC_BYTE = 8'hA5;
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t          state_r;
    state_t          state_nx_s;
    logic            cap_r;
    logic            drop_r;
    logic [7:0]      xor_r;
    logic [7:0]      rem_r;
    logic [TW-1:0]   to_cnt_r;
    logic [7:0]      byte_s;
    logic            take_s;
    logic            timeout_s;
    logic            len_bad_s;
    logic            issue_s;
    logic            unused_low_s;

    assign byte_s       = i_fifo_output_byte[31:24];
    assign unused_low_s = ^i_fifo_output_byte[23:0];
    // cap_r marks the cycle the FIFO q holds the byte requested one cycle earlier
    assign take_s       = cap_r && !drop_r;
    assign len_bad_s    = (byte_s == 8'd0) || (byte_s > MAX_LEN_B);
    assign timeout_s    = (state_r != ST_IDLE) && !take_s && (to_cnt_r == TO_LAST);

    // Next state: moves only on a captured byte or on starvation timeout
    always_comb begin
        state_nx_s = state_r;
        if (timeout_s) begin
            state_nx_s = ST_IDLE;
        end else if (take_s) begin
            case (state_r)
                ST_IDLE:    state_nx_s = (byte_s == SYNC_BYTE) ? ST_LEN : ST_IDLE;
                ST_LEN:     state_nx_s = len_bad_s ? ST_IDLE : ST_PAYLOAD;
                ST_PAYLOAD: state_nx_s = (rem_r == 8'd1) ? ST_CHECK : ST_PAYLOAD;
                ST_CHECK:   state_nx_s = ST_IDLE;
                default:    state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // A new read may go out on the same edge the previous byte lands, giving 2 clocks/byte
    assign issue_s = !o_read_next_byte_cmd && !i_fifo_is_empty_sig && !timeout_s &&
                     ((state_nx_s != ST_PAYLOAD) || i_sink_ready);

    // Sequencer state, read handshake, checksum, timeout and all registered outputs
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r              <= ST_IDLE;
            cap_r                <= 1'b0;
            drop_r               <= 1'b0;
            xor_r                <= 8'd0;
            rem_r                <= 8'd0;
            to_cnt_r             <= '0;
            o_read_next_byte_cmd <= 1'b0;
            o_payload_byte       <= 8'd0;
            o_payload_valid      <= 1'b0;
            o_packet_start       <= 1'b0;
            o_packet_done        <= 1'b0;
            o_packet_ok          <= 1'b0;
            o_length             <= 8'd0;
            o_error_count        <= 8'd0;
        end else begin
            state_r              <= state_nx_s;
            o_read_next_byte_cmd <= issue_s;
            cap_r                <= o_read_next_byte_cmd;
            o_payload_valid      <= 1'b0;
            o_packet_start       <= 1'b0;
            o_packet_done        <= 1'b0;
            o_packet_ok          <= 1'b0;

            if ((state_nx_s == ST_IDLE) || take_s) begin
                to_cnt_r <= '0;
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end

            // A read still in flight at timeout belongs to the abandoned packet
            if (timeout_s) begin
                drop_r <= o_read_next_byte_cmd;
            end else if (cap_r) begin
                drop_r <= 1'b0;
            end

            if (timeout_s) begin
                o_packet_done <= (state_r != ST_LEN);
                o_error_count <= sat_inc(o_error_count);
            end else if (take_s) begin
                case (state_r)
                    ST_LEN: begin
                        if (len_bad_s) begin
                            o_error_count <= sat_inc(o_error_count);
                        end else begin
                            o_length       <= byte_s;
                            xor_r          <= byte_s;
                            rem_r          <= byte_s;
                            o_packet_start <= 1'b1;
                        end
                    end
                    ST_PAYLOAD: begin
                        o_payload_byte  <= byte_s;
                        o_payload_valid <= 1'b1;
                        xor_r           <= xor_r ^ byte_s;
                        rem_r           <= rem_r - 8'd1;
                    end
                    ST_CHECK: begin
                        o_packet_done <= 1'b1;
                        o_packet_ok   <= (byte_s == xor_r);
                        if (byte_s != xor_r) begin
                            o_error_count <= sat_inc(o_error_count);
                        end
                    end
                    default: begin
                        xor_r <= xor_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_packet_sequencer.sv
// Scoreboard bench for rx_packet_sequencer: a registered-output FIFO model feeds framed
// byte streams; expected start/payload/done events are queued at stimulus time.
module tb_rx_packet_sequencer;

    localparam int MAX_LEN = 8;
    localparam int TO_CLKS = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fifo_q = 32'd0;
    logic        fifo_empty = 1'b1;
    logic        rdreq;
    logic        sink_ready = 1'b1;
    logic [7:0]  payload_byte;
    logic        payload_valid;
    logic        packet_start;
    logic        packet_done;
    logic        packet_ok;
    logic [7:0]  length;
    logic [7:0]  error_count;

    always #5 clk = ~clk;

    rx_packet_sequencer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TO_CLKS)) dut (
        .i_clock              (clk),
        .i_reset              (rst),
        .i_fifo_output_byte   (fifo_q),
        .i_fifo_is_empty_sig  (fifo_empty),
        .o_read_next_byte_cmd (rdreq),
        .i_sink_ready         (sink_ready),
        .o_payload_byte       (payload_byte),
        .o_payload_valid      (payload_valid),
        .o_packet_start       (packet_start),
        .o_packet_done        (packet_done),
        .o_packet_ok          (packet_ok),
        .o_length             (length),
        .o_error_count        (error_count)
    );

    // FIFO model: q updates one edge after rdreq, low 24 bits are noise
    logic [7:0] mem [0:4095];
    int wr_idx = 0;
    int rd_idx = 0;
    int viol   = 0;

    always @(posedge clk) begin
        if (rdreq && (rd_idx != wr_idx)) begin
            fifo_q     <= {mem[rd_idx], 24'($urandom)};
            rd_idx     <= rd_idx + 1;
            fifo_empty <= ((rd_idx + 1) == wr_idx);
        end else begin
            if (rdreq) viol <= viol + 1;
            fifo_empty <= (rd_idx == wr_idx);
        end
    end

    typedef struct { int kind; int val; } ev_t;
    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  exp_err  = 0;
    int  n_valid  = 0;
    int  stall_rd = 0;
    int  stall_valid = 0;
    bit  stall_mon = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_idx] = b;
        wr_idx++;
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_evt", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("evt_kind", kind, e.kind);
            case (kind)
                1:       check_eq("start_length", val, e.val);
                2:       check_eq("payload_byte", val, e.val);
                default: check_eq("done_ok", val, e.val);
            endcase
        end
    endtask

    // one clock; outputs sampled on the falling edge
    task automatic step();
        @(negedge clk);
        if (packet_start) pop_cmp(1, int'(length));
        if (payload_valid) begin
            pop_cmp(2, int'(payload_byte));
            n_valid++;
        end
        if (packet_done) pop_cmp(3, int'(packet_ok));
        if (stall_mon) begin
            if (rdreq) stall_rd++;
            if (payload_valid) stall_valid++;
        end
    endtask

    task automatic send_pkt(input int len, input logic [7:0] first,
                            input logic [7:0] stp, input logic [7:0] flip);
        logic [7:0] b;
        logic [7:0] chk;
        push_byte(8'hA5);
        push_byte(len[7:0]);
        expect_ev(1, len);
        chk = len[7:0];
        b   = first;
        for (int i = 0; i < len; i++) begin
            push_byte(b);
            expect_ev(2, int'(b));
            chk = chk ^ b;
            b   = b + stp;
        end
        push_byte(chk ^ flip);
        expect_ev(3, (flip == 8'd0) ? 1 : 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!((exp_q.size() == 0) && (rd_idx == wr_idx)) && (n < budget)) begin
            step();
            n++;
        end
        if (n >= budget) check_eq("idle_budget", 1, 0);
        repeat (6) step();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_rdreq"},   int'(rdreq), 0);
        check_eq({tag, "_pbyte"},   int'(payload_byte), 0);
        check_eq({tag, "_pvalid"},  int'(payload_valid), 0);
        check_eq({tag, "_start"},   int'(packet_start), 0);
        check_eq({tag, "_done"},    int'(packet_done), 0);
        check_eq({tag, "_ok"},      int'(packet_ok), 0);
        check_eq({tag, "_length"},  int'(length), 0);
        check_eq({tag, "_errors"},  int'(error_count), 0);
    endtask

    initial begin
        int base;
        int k;
        int n;

        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        #1;
        check_eq("rdreq_at_release", int'(rdreq), 0);

        // good packet, then same packet with a bad checksum
        send_pkt(3, 8'h11, 8'h11, 8'h00);
        wait_idle(500);
        check_eq("good_length", int'(length), 3);
        check_eq("good_errors", int'(error_count), exp_err);
        send_pkt(3, 8'h11, 8'h11, 8'h07);
        exp_err++;
        wait_idle(500);
        check_eq("badchk_errors", int'(error_count), exp_err);

        // leading garbage, LEN=0, then a 1-byte packet
        push_byte(8'h00); push_byte(8'h7F); push_byte(8'hA5); push_byte(8'h00);
        exp_err++;
        send_pkt(1, 8'h5A, 8'h00, 8'h00);
        wait_idle(500);
        check_eq("len0_errors", int'(error_count), exp_err);
        check_eq("len0_length", int'(length), 1);

        // LEN above MAX_LEN, then 0xA5 carried as payload data
        push_byte(8'hA5); push_byte(8'(MAX_LEN + 1));
        exp_err++;
        send_pkt(2, 8'hA5, 8'h00, 8'h00);
        wait_idle(500);
        check_eq("lenmax_errors", int'(error_count), exp_err);
        send_pkt(MAX_LEN, 8'hF0, 8'h03, 8'h00);
        wait_idle(500);
        check_eq("maxlen_length", int'(length), MAX_LEN);

        // starvation mid-payload
        push_byte(8'hA5); push_byte(8'h02); push_byte(8'hAA);
        expect_ev(1, 2);
        expect_ev(2, 8'hAA);
        expect_ev(3, 0);
        exp_err++;
        wait_idle(4 * TO_CLKS);
        check_eq("timeout_errors", int'(error_count), exp_err);
        send_pkt(1, 8'h33, 8'h00, 8'h00);
        wait_idle(500);
        check_eq("after_timeout_length", int'(length), 1);

        // starvation in LEN: error but no done pulse
        push_byte(8'hA5);
        repeat (TO_CLKS + 60) step();
        exp_err++;
        check_eq("len_timeout_errors", int'(error_count), exp_err);

        // sink stall mid-payload
        send_pkt(4, 8'h01, 8'h01, 8'h00);
        base = n_valid;
        k = 0;
        while ((n_valid == base) && (k < 200)) begin step(); k++; end
        check_eq("stall_first_byte", n_valid - base, 1);
        sink_ready = 1'b0;
        repeat (3) step();
        stall_mon = 1'b1;
        repeat (100) step();
        stall_mon = 1'b0;
        sink_ready = 1'b1;
        wait_idle(500);
        check_eq("stall_rdreq", stall_rd, 0);
        check_eq("stall_strobes", stall_valid, 0);
        check_eq("stall_errors", int'(error_count), exp_err);

        // error counter saturation
        n = 255 - exp_err + 3;
        for (int i = 0; i < n; i++) begin
            push_byte(8'hA5);
            push_byte(8'h00);
        end
        exp_err = 255;
        wait_idle(6000);
        check_eq("sat_errors", int'(error_count), 255);

        // reset mid-payload
        send_pkt(5, 8'h10, 8'h10, 8'h00);
        base = n_valid;
        k = 0;
        while ((n_valid < base + 2) && (k < 200)) begin step(); k++; end
        check_eq("pre_reset_bytes", n_valid - base, 2);
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        exp_err = 0;
        step();
        step();
        rst = 1'b0;
        send_pkt(1, 8'h77, 8'h00, 8'h00);
        wait_idle(500);
        check_eq("post_reset_errors", int'(error_count), exp_err);
        check_eq("post_reset_length", int'(length), 1);

        check_eq("rd_on_empty", viol, 0);
        check_eq("events_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_packet_sequencer.md
RX_PACKET_SEQUENCER -- requirements
Module: rx_packet_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 64, SHALL set the largest legal payload length in bytes (1..255).
REQ-002 Parameter TIMEOUT_CLKS, default 50000, SHALL set the mid-packet starvation limit in clocks (1 ms at 50 MHz).
REQ-003 i_clock  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 i_fifo_output_byte  in  32  SHALL be the RX FIFO q; the byte is in [31:24] and [23:0] is ignored.
REQ-006 i_fifo_is_empty_sig  in  1  SHALL be the RX FIFO empty flag.
REQ-007 o_read_next_byte_cmd  out  1  SHALL be the FIFO rdreq, a 1-cycle pulse per byte.
REQ-008 i_sink_ready  in  1  SHALL be the downstream ready for payload bytes.
REQ-009 o_payload_byte  out  8  SHALL be the payload byte, valid only with o_payload_valid.
REQ-010 o_payload_valid  out  1  SHALL be a 1-cycle strobe, one per payload byte.
REQ-011 o_packet_start  out  1  SHALL pulse for 1 cycle when a valid length byte is accepted.
REQ-012 o_packet_done  out  1  SHALL pulse for 1 cycle at the end of every packet attempt that passes the length byte.
REQ-013 o_packet_ok  out  1  SHALL be qualified by o_packet_done: 1 means the checksum matched.
REQ-014 o_length  out  8  SHALL hold the accepted length from o_packet_start until the next o_packet_start.
REQ-015 o_error_count  out  8  SHALL count errors and saturate at 0xFF.

Function
REQ-016 Frame format SHALL be: sync 0xA5, LEN, LEN payload bytes, CHK; CHK = XOR of LEN and all payload bytes.
REQ-017 States SHALL be IDLE (hunt sync), LEN, PAYLOAD, CHECK.
- All transitions occur on byte capture, timeout or reset.
REQ-018 Read handshake:
- Assert o_read_next_byte_cmd only when i_fifo_is_empty_sig=0 and no read is outstanding.
- In PAYLOAD, i_sink_ready=1 is also required.
- Only one read may be outstanding.
REQ-019 Capture timing: the byte SHALL be captured from i_fifo_output_byte[31:24] exactly 1 cycle after rdreq.
- Maximum throughput is therefore one byte per 2 clocks.
REQ-020 IDLE:
- Byte 0xA5 goes to LEN.
- Any other byte is discarded silently, stays in IDLE and is not counted as an error.
REQ-021 LEN:
- LEN=0 or LEN>MAX_LEN: increment o_error_count, go to IDLE, no done pulse.
- Otherwise: latch o_length, clear running XOR to LEN, pulse o_packet_start, go to PAYLOAD.
REQ-022 PAYLOAD:
- Each captured byte drives o_payload_byte/o_payload_valid in the cycle after capture and is XORed into the checksum.
- After the LEN-th byte, go to CHECK.
REQ-023 CHECK:
- Pulse o_packet_done; o_packet_ok = (CHK == running XOR).
- On mismatch, increment o_error_count.
- Go to IDLE.
REQ-024 Payload bytes SHALL be forwarded unbuffered; downstream discards the packet on o_packet_ok=0.
REQ-025 Timeout:
- In LEN, PAYLOAD or CHECK, a cycle counter increments while no byte is captured and resets on every capture.
- On reaching TIMEOUT_CLKS: pulse o_packet_done with o_packet_ok=0 (LEN state: no done pulse), increment o_error_count, go to IDLE.
- Any outstanding read completes and its byte is discarded.
REQ-026 i_sink_ready=0 SHALL stall reads but SHALL NOT stop the timeout counter.
REQ-027 Byte 0xA5 inside LEN/PAYLOAD/CHECK SHALL be treated as data, with no resync.
REQ-028 o_error_count at 0xFF SHALL stay at 0xFF on further errors.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Asserting i_reset at any time, including mid-packet, SHALL immediately:
- Force IDLE.
- Clear the outstanding-read flag, timeout counter and XOR.
- Drive every output to 0, including o_length and o_error_count.
REQ-031 After reset release, no rdreq SHALL issue before the first rising edge with i_reset=0.

Verification
REQ-032 FIFO holds A5 03 11 22 33 03, sink ready -> o_packet_start, then payload 11/22/33, then o_packet_done=1 with o_packet_ok=1, o_length=3, errors=0.
REQ-033 Same packet with CHK=04 -> 3 payload strobes, then done=1, ok=0, o_error_count=1.
REQ-034 Stream 00 7F A5 00 A5 01 5A 5B -> leading bytes dropped; LEN=0 gives error=1 and no done; next packet ok with payload 5A.
REQ-035 A5 02 AA, then FIFO empty for TIMEOUT_CLKS -> done=1, ok=0, error=1, state IDLE; a following valid packet passes.
REQ-036 i_sink_ready=0 for 100 cycles mid-payload -> no rdreq and no payload strobe during the stall; the packet completes ok after ready returns.
REQ-037 i_reset pulsed during PAYLOAD -> all outputs 0 asynchronously; the remaining bytes are hunted as garbage until the next A5.
